// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core with one shared memory port.
// Next state is registered; control outputs decode the state, a few gated by mem_ready/take_branch.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       take_branch,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JUMP, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    state_t r_state;
    // op is only valid in DECODE, so the load/store choice is carried into MEM_ADR here
    logic   r_is_store;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_is_store <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE:      r_state <= S_FETCH;
                S_FETCH:     if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_is_store <= (op == OP_STORE);
                    case (op)
                        OP_LOAD, OP_STORE: r_state <= S_MEM_ADR;
                        OP_OP:             r_state <= S_EXEC_R;
                        OP_OPIMM:          r_state <= S_EXEC_I;
                        OP_BRANCH:         r_state <= S_BRANCH;
                        OP_JAL:            r_state <= S_JUMP;
                        OP_JALR:           r_state <= S_JALR_ADR;
                        OP_LUI:            r_state <= S_LUI;
                        OP_AUIPC:          r_state <= S_AUIPC;
                        default:           r_state <= S_TRAP;
                    endcase
                end
                S_MEM_ADR:   r_state <= r_is_store ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
                S_MEM_WB:    r_state <= S_FETCH;
                S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_JUMP: r_state <= S_ALU_WB;
                S_ALU_WB, S_BRANCH: r_state <= S_FETCH;
                S_JALR_ADR:  r_state <= S_JUMP;
                S_TRAP:      r_state <= S_TRAP;
            endcase
        end
    end

    // Reset overrides everything so an in-flight memory request is dropped immediately
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        imm_src    = IMM_I;
        retire     = 1'b0;
        trap       = 1'b0;
        state      = 4'd0;
        if (!rst) begin
            state = r_state;
            case (r_state)
                S_IDLE: ;
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEM_ADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = r_is_store ? IMM_S : IMM_I;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    retire     = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = take_branch;
                    retire    = 1'b1;
                end
                S_JALR_ADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                S_AUIPC: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_U;
                end
                S_TRAP: trap = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: a per-instruction state trace and output table built from the
// instruction-class rules, compared cycle by cycle, plus FETCH-to-retire latency checks.
module tb_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       take_branch, mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, retire, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .take_branch(take_branch), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .imm_src(imm_src), .retire(retire), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    // State numbering follows the order the states are listed for the block
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADR = 3, S_MEM_READ = 4,
                   S_MEM_WB = 5, S_MEM_WRITE = 6, S_EXEC_R = 7, S_EXEC_I = 8, S_ALU_WB = 9,
                   S_BRANCH = 10, S_JALR_ADR = 11, S_JUMP = 12, S_LUI = 13, S_AUIPC = 14,
                   S_TRAP = 15;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                           OPI = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                           JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    logic [22:0] w_obs;
    assign w_obs = {state, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                    alu_src_a, alu_src_b, alu_op, result_src, imm_src, retire, trap};

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control word for one cycle of a given state
    function automatic logic [22:0] exp_out(input int st, input bit rdy, input bit tbr,
                                            input bit jal, input bit store);
        logic       req = 0, we = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ret = 0, trp = 0;
        logic [1:0] a = 0, b = 0, alu = 0, rs = 0;
        logic [2:0] imm = 0;
        case (st)
            S_FETCH:     begin req = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            S_DECODE:    begin a = 1; b = 1; imm = jal ? 3'd4 : 3'd2; end
            S_MEM_ADR:   begin a = 2; b = 1; imm = store ? 3'd1 : 3'd0; end
            S_MEM_READ:  begin req = 1; adr = 1; end
            S_MEM_WB:    begin rs = 1; rw = 1; ret = 1; end
            S_MEM_WRITE: begin req = 1; we = 1; adr = 1; ret = rdy; end
            S_EXEC_R:    begin a = 2; alu = 2; end
            S_EXEC_I:    begin a = 2; b = 1; alu = 2; end
            S_ALU_WB:    begin rw = 1; ret = 1; end
            S_BRANCH:    begin a = 2; alu = 1; pcw = tbr; ret = 1; end
            S_JALR_ADR:  begin a = 2; b = 1; end
            S_JUMP:      begin pcw = 1; a = 1; b = 2; end
            S_LUI:       begin a = 3; b = 1; imm = 3; end
            S_AUIPC:     begin a = 1; b = 1; imm = 3; end
            S_TRAP:      trp = 1;
            default: ;
        endcase
        return {4'(st), req, we, adr, irw, pcw, rw, a, b, alu, rs, imm, ret, trp};
    endfunction

    // Drive one cycle, check it at the falling edge, leave inputs changeable after the next rise
    task automatic step(input int st, input bit rdy, input logic [6:0] opc, input bit tbr,
                        output bit ret);
        op          = (st == S_DECODE) ? opc : 7'($urandom);
        mem_ready   = rdy;
        take_branch = (st == S_BRANCH) ? tbr : 1'($urandom);
        @(negedge clk);
        chk($sformatf("op%0h_state%0d", opc, st), 32'(w_obs),
            32'(exp_out(st, rdy, tbr, opc == JAL, opc == STORE)));
        ret = retire;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bit r;
        rst = 1'b1; mem_ready = 1'b1; op = 7'($urandom); take_branch = 1'b1;
        @(negedge clk);
        chk("reset_outputs_zero", 32'(w_obs), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(S_IDLE, 1'($urandom), 7'd0, 1'b0, r);
    endtask

    // Builds the state trace for one instruction from its class, then checks it cycle by cycle
    task automatic run_instr(input logic [6:0] opc, input int sf, input int sm, input bit tbr);
        int  q_st[$];
        bit  q_rdy[$];
        int  base = 0, lat = 0, nret = 0;
        bit  r;
        for (int i = 0; i < sf; i++) begin q_st.push_back(S_FETCH); q_rdy.push_back(0); end
        q_st.push_back(S_FETCH);  q_rdy.push_back(1);
        q_st.push_back(S_DECODE); q_rdy.push_back(1'($urandom));
        case (opc)
            LOAD, STORE: begin
                q_st.push_back(S_MEM_ADR); q_rdy.push_back(1'($urandom));
                for (int i = 0; i < sm; i++) begin
                    q_st.push_back(opc == LOAD ? S_MEM_READ : S_MEM_WRITE); q_rdy.push_back(0);
                end
                q_st.push_back(opc == LOAD ? S_MEM_READ : S_MEM_WRITE); q_rdy.push_back(1);
                if (opc == LOAD) begin q_st.push_back(S_MEM_WB); q_rdy.push_back(1'($urandom)); end
                base = (opc == LOAD) ? 5 : 4;
            end
            OPR, OPI, LUI, AUIPC, JAL: begin
                q_st.push_back(opc == OPR ? S_EXEC_R : opc == OPI ? S_EXEC_I :
                               opc == LUI ? S_LUI : opc == AUIPC ? S_AUIPC : S_JUMP);
                q_rdy.push_back(1'($urandom));
                q_st.push_back(S_ALU_WB); q_rdy.push_back(1'($urandom));
                base = 4;
            end
            JALR: begin
                q_st.push_back(S_JALR_ADR); q_rdy.push_back(1'($urandom));
                q_st.push_back(S_JUMP);     q_rdy.push_back(1'($urandom));
                q_st.push_back(S_ALU_WB);   q_rdy.push_back(1'($urandom));
                base = 5;
            end
            BR: begin q_st.push_back(S_BRANCH); q_rdy.push_back(1'($urandom)); base = 3; end
            default: for (int i = 0; i < 10; i++) begin
                q_st.push_back(S_TRAP); q_rdy.push_back(1'($urandom));
            end
        endcase
        for (int k = 0; k < q_st.size(); k++) begin
            step(q_st[k], q_rdy[k], opc, tbr, r);
            if (r) begin nret++; lat = k + 1; end
        end
        chk($sformatf("retire_count_op%0h", opc), nret, (base > 0) ? 1 : 0);
        if (base > 0) chk($sformatf("latency_op%0h", opc), lat, base + sf + (opc == BR ? 0 : sm));
    endtask

    logic [6:0] legal [9] = '{LOAD, STORE, OPR, OPI, BR, JAL, JALR, LUI, AUIPC};

    initial begin
        bit r;
        rst = 1'b1; op = '0; take_branch = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        run_instr(OPR, 0, 0, 0);
        run_instr(LOAD, 2, 2, 0);
        run_instr(BR, 0, 0, 1);
        run_instr(BR, 0, 0, 0);
        run_instr(JAL, 0, 0, 0);
        run_instr(JALR, 0, 0, 0);
        for (int n = 0; n < 60; n++) begin
            logic [6:0] o;
            int sf, sm;
            o  = legal[$urandom_range(0, 8)];
            sf = $urandom_range(0, 3);
            sm = (o == LOAD || o == STORE) ? $urandom_range(0, 3) : 0;
            run_instr(o, sf, sm, 1'($urandom));
        end
        // Store abandoned by reset in the middle of its memory stall
        step(S_FETCH, 1, STORE, 0, r);
        step(S_DECODE, 1, STORE, 0, r);
        step(S_MEM_ADR, 0, STORE, 0, r);
        for (int i = 0; i < 3; i++) begin
            step(S_MEM_WRITE, 0, STORE, 0, r);
            chk("store_stall_no_retire", 32'(r), 32'd0);
        end
        do_reset();
        run_instr(STORE, 1, 1, 0);
        // Illegal opcode locks in TRAP until reset
        run_instr(7'b0000000, 0, 0, 0);
        do_reset();
        run_instr(OPI, 0, 0, 0);
        run_instr(7'b1111111, 1, 0, 0);
        do_reset();
        run_instr(LUI, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
